// File: rtl/mem_wb_if.sv
// MEM/WB write-back bus: memory-stage inputs, pipeline control, register-file
// write port, retirement count and decode-stage operand bypass.
interface mem_wb_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic              mem_regwrite;
    logic              mem_memtoreg;
    logic [4:0]        mem_rd;
    logic [DATA_W-1:0] mem_aluresult;
    logic [DATA_W-1:0] mem_readdata;
    logic [4:0]        dec_rs;
    logic [4:0]        dec_rt;
    logic [DATA_W-1:0] dec_a_in;
    logic [DATA_W-1:0] dec_b_in;
    logic              regwrite;
    logic [4:0]        rd;
    logic [DATA_W-1:0] writedata;
    logic              wb_valid;
    logic [CNT_W-1:0]  retired_count;
    logic [DATA_W-1:0] dec_a_out;
    logic [DATA_W-1:0] dec_b_out;

    modport master (
        output stall, flush, mem_valid, mem_regwrite, mem_memtoreg, mem_rd,
               mem_aluresult, mem_readdata, dec_rs, dec_rt, dec_a_in, dec_b_in,
        input  regwrite, rd, writedata, wb_valid, retired_count, dec_a_out, dec_b_out
    );

    modport slave (
        input  stall, flush, mem_valid, mem_regwrite, mem_memtoreg, mem_rd,
               mem_aluresult, mem_readdata, dec_rs, dec_rt, dec_a_in, dec_b_in,
        output regwrite, rd, writedata, wb_valid, retired_count, dec_a_out, dec_b_out
    );
endinterface

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and register-file write port with single-write/single-count under stall.
// Optional feature: define WB_BYPASS_EN to forward the value being written to the decode operands.
module mem_wb_writeback #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic    clk,
    input  logic    rst,
    mem_wb_if.slave bus
);
    logic              wb_valid_q,    wb_valid_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic [4:0]        rd_q,          rd_d;
    logic [DATA_W-1:0] writedata_q,   writedata_d;
    logic              done_q,        done_d;
    logic [CNT_W-1:0]  retired_count_q, retired_count_d;
    logic              retire;
    logic              regwrite;

    // done marks that the held instruction already wrote and was counted
    assign retire   = wb_valid_q & ~done_q;
    assign regwrite = wb_valid_q & wb_regwrite_q & (rd_q != 5'd0) & ~done_q;

    always_comb begin
        wb_valid_d      = wb_valid_q;
        wb_regwrite_d   = wb_regwrite_q;
        rd_d            = rd_q;
        writedata_d     = writedata_q;
        done_d          = done_q;
        retired_count_d = retired_count_q + {{(CNT_W-1){1'b0}}, retire};
        if (bus.flush) begin
            wb_valid_d = 1'b0;
            done_d     = 1'b0;
        end else if (bus.stall) begin
            if (wb_valid_q) done_d = 1'b1;
        end else begin
            wb_valid_d    = bus.mem_valid;
            wb_regwrite_d = bus.mem_regwrite;
            rd_d          = bus.mem_rd;
            writedata_d   = bus.mem_memtoreg ? bus.mem_readdata : bus.mem_aluresult;
            done_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q      <= 1'b0;
            wb_regwrite_q   <= 1'b0;
            rd_q            <= 5'd0;
            writedata_q     <= '0;
            done_q          <= 1'b0;
            retired_count_q <= '0;
        end else begin
            wb_valid_q      <= wb_valid_d;
            wb_regwrite_q   <= wb_regwrite_d;
            rd_q            <= rd_d;
            writedata_q     <= writedata_d;
            done_q          <= done_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign bus.regwrite      = regwrite;
    assign bus.rd            = rd_q;
    assign bus.writedata     = writedata_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.retired_count = retired_count_q;

`ifdef WB_BYPASS_EN
    assign bus.dec_a_out = (regwrite && rd_q == bus.dec_rs) ? writedata_q : bus.dec_a_in;
    assign bus.dec_b_out = (regwrite && rd_q == bus.dec_rt) ? writedata_q : bus.dec_b_in;
`else
    logic unused_dec;
    assign unused_dec    = ^{bus.dec_rs, bus.dec_rt};
    assign bus.dec_a_out = bus.dec_a_in;
    assign bus.dec_b_out = bus.dec_b_in;
`endif
endmodule

// File: tb/tb_mem_wb_writeback.sv
// Scoreboard bench for mem_wb_writeback: directed test-plan cases then random traffic,
// with an 8-bit retire counter so wrap-around is reached naturally.
module tb_mem_wb_writeback;
    localparam int DW = 32;
    localparam int CW = 8;

    typedef struct {
        int              cyc;
        bit              rw;
        logic [4:0]      rd;
        logic [DW-1:0]   wd;
        bit              v;
        logic [CW-1:0]   cnt;
    } main_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } dec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    int   fix_rs = -1;

    main_t mq[$];
    dec_t  dq[$];

    // Reference: the instruction sitting in WB and whether it has already retired
    bit            m_valid = 0;
    bit            m_rw = 0;
    logic [4:0]    m_rd = 0;
    logic [DW-1:0] m_data = 0;
    bit            m_retired = 0;
    int            m_count = 0;

    mem_wb_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    mem_wb_writeback #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (dq.size() > 0 && dq[0].cyc <= cyc) begin
                    dec_t d;
                    d = dq.pop_front();
                    chk("dec_a_out", bus.dec_a_out, d.a);
                    chk("dec_b_out", bus.dec_b_out, d.b);
                end
                while (mq.size() > 0 && mq[0].cyc <= cyc) begin
                    main_t m;
                    m = mq.pop_front();
                    chk("regwrite", {31'd0, bus.regwrite}, {31'd0, m.rw});
                    chk("wb_valid", {31'd0, bus.wb_valid}, {31'd0, m.v});
                    chk("retired_count", {24'd0, bus.retired_count}, {24'd0, m.cnt});
                    if (m.v) begin
                        chk("rd", {27'd0, bus.rd}, {27'd0, m.rd});
                        chk("writedata", bus.writedata, m.wd);
                    end
                end
            end
        end
    end

    // Called just after a rising edge; drives inputs for the next edge and queues expectations.
    task automatic step(input bit v, input bit rw, input bit m2r, input logic [4:0] r,
                        input logic [DW-1:0] alu, input logic [DW-1:0] rdat,
                        input bit st, input bit fl);
        logic [4:0]    rs, rt;
        logic [DW-1:0] ain, bin, aexp, bexp;
        bit            wr_now;
        dec_t          d;
        main_t         m;
        rs  = ($urandom_range(0, 1) == 1) ? m_rd : 5'($urandom_range(0, 31));
        rt  = ($urandom_range(0, 1) == 1) ? m_rd : 5'($urandom_range(0, 31));
        ain = $urandom;
        bin = $urandom;
        if (fix_rs >= 0) begin
            rs  = 5'(fix_rs);
            ain = '0;
        end
        bus.mem_valid     = v;
        bus.mem_regwrite  = rw;
        bus.mem_memtoreg  = m2r;
        bus.mem_rd        = r;
        bus.mem_aluresult = alu;
        bus.mem_readdata  = rdat;
        bus.stall         = st;
        bus.flush         = fl;
        bus.dec_rs        = rs;
        bus.dec_rt        = rt;
        bus.dec_a_in      = ain;
        bus.dec_b_in      = bin;

        wr_now = m_valid && m_rw && (m_rd != 0) && !m_retired;
        aexp = ain;
        bexp = bin;
`ifdef WB_BYPASS_EN
        if (wr_now && m_rd == rs) aexp = m_data;
        if (wr_now && m_rd == rt) bexp = m_data;
`endif
        d.cyc = cyc; d.a = aexp; d.b = bexp;
        dq.push_back(d);

        if (m_valid && !m_retired) m_count = (m_count + 1) % (1 << CW);
        if (fl) begin
            m_valid = 0;
            m_retired = 0;
        end else if (st) begin
            if (m_valid) m_retired = 1;
        end else begin
            m_valid = v; m_rw = rw; m_rd = r;
            m_data = m2r ? rdat : alu;
            m_retired = 0;
        end
        m.cyc = cyc + 1;
        m.rw  = m_valid && m_rw && (m_rd != 0) && !m_retired;
        m.rd  = m_rd;
        m.wd  = m_data;
        m.v   = m_valid;
        m.cnt = CW'(m_count);
        mq.push_back(m);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.stall = 0; bus.flush = 0; bus.mem_valid = 0; bus.mem_regwrite = 0;
        bus.mem_memtoreg = 0; bus.mem_rd = 0; bus.mem_aluresult = 0; bus.mem_readdata = 0;
        bus.dec_rs = 0; bus.dec_rt = 0; bus.dec_a_in = 0; bus.dec_b_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset regwrite", {31'd0, bus.regwrite}, 32'd0);
        chk("reset wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("reset count", {24'd0, bus.retired_count}, 32'd0);
        chk("reset writedata", bus.writedata, 32'd0);
        chk("reset rd", {27'd0, bus.rd}, 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;

        step(1, 1, 0, 5'd5, 32'h0000_00AA, 32'h0, 0, 0);
        step(1, 1, 1, 5'd9, 32'h1111_1111, 32'hDEAD_BEEF, 0, 0);
        step(1, 1, 0, 5'd0, 32'h2222_2222, 32'h0, 0, 0);
        step(1, 1, 0, 5'd7, 32'h0000_0077, 32'h0, 0, 0);
        repeat (3) step(1, 1, 0, 5'd8, 32'h8888_8888, 32'h0, 1, 0);
        step(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
        step(1, 1, 0, 5'd4, 32'h4444_4444, 32'h0, 1, 1);
        step(1, 1, 0, 5'd3, 32'h0000_1234, 32'h0, 0, 0);
        fix_rs = 3;
        step(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
        fix_rs = -1;

        for (int i = 0; i < 700; i++) begin
            bit st, fl;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            step(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 $urandom, $urandom, st, fl);
        end

        step(1, 1, 0, 5'd6, 32'h0000_0066, 32'h0, 0, 0);
        @(negedge clk);
        mon_en = 1'b0;
        chk("queue drained", 32'(mq.size()), 32'd0);
        @(posedge clk);
        #1;
        chk("pre-reset regwrite", {31'd0, bus.regwrite}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async regwrite", {31'd0, bus.regwrite}, 32'd0);
        chk("async wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("async count", {24'd0, bus.retired_count}, 32'd0);
        chk("async writedata", bus.writedata, 32'd0);
        chk("async rd", {27'd0, bus.rd}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

Write-back stage of the 5-stage pipeline: holds the MEM/WB pipeline register, selects the write-back value, and drives the register file's write port (`regwrite`, `rd`, `writedata`). It sits between the memory stage and the decode-stage register file. It guarantees each retiring instruction writes at most once and is counted once, even under stall. Optionally, it bypasses the value being written to the decode-stage read data.

## Interface
- `DATA_W`, 32, datapath width
- `CNT_W`, 32, retired-instruction counter width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold MEM/WB contents this cycle
- `flush`  in  1  squash the instruction entering MEM/WB
- `mem_valid`  in  1  memory-stage slot holds a real instruction
- `mem_regwrite`  in  1  instruction writes a register
- `mem_memtoreg`  in  1  1 = load data, 0 = ALU result
- `mem_rd`  in  5  destination register
- `mem_aluresult`  in  DATA_W  ALU result
- `mem_readdata`  in  DATA_W  data-memory read data
- `dec_rs`, `dec_rt`  in  5 each  decode-stage source register numbers
- `dec_a_in`, `dec_b_in`  in  DATA_W each  register-file read data
- `regwrite`  out  1  register-file write enable
- `rd`  out  5  register-file write address
- `writedata`  out  DATA_W  register-file write data
- `wb_valid`  out  1  MEM/WB holds a real instruction
- `retired_count`  out  CNT_W  instructions retired since reset
- `dec_a_out`, `dec_b_out`  out  DATA_W each  operands to the ID/EX register

## Operation
- Registered state: `wb_valid`, `wb_regwrite`, `rd`, `writedata`, `done`, `retired_count`.
- On reset (`rst`=0, asynchronous): all registered state is 0. `regwrite`=0.
- Capture at each rising edge, in priority order:
  - `flush`=1: `wb_valid`<=0 and `done`<=0. Other fields don't care. Flush overrides stall.
  - `stall`=1: all fields hold. `done`<=1 if `wb_valid`.
  - Otherwise: `wb_valid`<=`mem_valid`, `wb_regwrite`<=`mem_regwrite`, `rd`<=`mem_rd`, and `done`<=0.
  - `writedata`<=`mem_memtoreg` ? `mem_readdata` : `mem_aluresult`. The mux sits before the register.
- `regwrite` = `wb_valid` & `wb_regwrite` & (`rd`!=0) & ~`done`. This is combinational from registered state only.
- As a result, a held instruction writes exactly once: in its first cycle in MEM/WB.
- Writes to `rd`=0 are suppressed here, independently of the register file.
- `retired_count` increments by 1 at the end of each cycle where `wb_valid` & ~`done`. It wraps from 2^CNT_W−1 to 0. Bubbles never count.

## Timing
- Latency: inputs captured at edge k appear on `regwrite`/`rd`/`writedata` during cycle k+1. The register file commits at edge k+1.
- `retired_count` reflects an instruction one edge after its first WB cycle.
- `stall` and `flush` are sampled at the edge. Neither has any combinational effect on outputs.
- `flush` together with `stall`: flush wins, so the slot becomes a bubble.
- Reset asserted mid-stall: state clears immediately. `regwrite` drops in the same cycle, without waiting for a clock edge.
- Reset release is synchronous to `clk` and is the integrator's responsibility. The first capture happens on the first edge with `rst`=1.

## Configuration
- `WB_BYPASS_EN` defined:
  - `dec_a_out` = (`regwrite` && `rd`==`dec_rs`) ? `writedata` : `dec_a_in`.
  - `dec_b_out` is the same using `dec_rt`.
  - This covers the same-cycle write/read hazard, since the register file writes at the edge but reads combinationally.
- `WB_BYPASS_EN` undefined:
  - `dec_a_out`=`dec_a_in` and `dec_b_out`=`dec_b_in` (pure pass-through).
  - The ports stay present, so the module's interface is identical in both builds.

## Test plan
- Reset, then one ALU instruction (`mem_valid`=1, `mem_regwrite`=1, `mem_memtoreg`=0, `mem_rd`=5, `mem_aluresult`=0x0000_00AA) -> next cycle `regwrite`=1, `rd`=5, `writedata`=0xAA. The following edge gives `retired_count`=1.
- Load with `mem_memtoreg`=1, `mem_readdata`=0xDEAD_BEEF, `mem_rd`=9 -> `writedata`=0xDEADBEEF, `regwrite`=1. `mem_rd`=0 instead -> `regwrite`=0, but `retired_count` still increments.
- Capture a valid write to r7, then hold `stall`=1 for 3 cycles -> `regwrite`=1 in the first cycle only, then 0. `retired_count` increments once.
- `flush`=1 and `stall`=1 on the same edge with a valid instruction at MEM -> `wb_valid`=0, `regwrite`=0, count unchanged.
- Preload `retired_count` to 0xFFFF_FFFF (force), then retire one instruction -> count becomes 0. Assert `rst`=0 mid-cycle -> all outputs 0 immediately.
- `WB_BYPASS_EN` build: write r3=0x1234 while `dec_rs`=3 and `dec_a_in`=0 -> `dec_a_out`=0x1234. Non-bypass build: `dec_a_out`=0.
